// File: rtl/dino_game_core.sv
// Frame-rate engine for the dinosaur runner: jump physics, an obstacle pool with spawn timer
// and speed ramp, collision detection, scoring and the IDLE/RUN/OVER game state machine.
module dino_game_core #(
    parameter int COORD_W     = 12,
    parameter int NUM_OBST    = 3,
    parameter int GROUND_Y    = 400,
    parameter int DINO_X      = 80,
    parameter int HEAD_DX     = 12,
    parameter int HEAD_DY     = 40,
    parameter int JUMP_V      = 12,
    parameter int GRAVITY     = 1,
    parameter int OBST_INIT_X = 640,
    parameter int OBST_W      = 16,
    parameter int OBST_H      = 32,
    parameter int SPAWN_GAP   = 90,
    parameter int SPEED_INIT  = 4,
    parameter int SPEED_MAX   = 12,
    parameter int SPEED_STEP  = 8,
    parameter int NIGHT_BIT   = 5
) (
    input  logic                         game_clk,
    input  logic                         rst_n,
    input  logic                         jump,
    input  logic                         start,
    output logic [COORD_W-1:0]           dino_y,
    output logic [NUM_OBST*COORD_W-1:0]  obstacle_x,
    output logic [NUM_OBST-1:0]          obst_active,
    output logic [15:0]                  score,
    output logic                         night,
    output logic                         game_over
);

    localparam int CNT_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam int RET_W = $clog2(NUM_OBST + 1);
    localparam int SHIFT = $clog2(SPEED_STEP);
    localparam int XW    = COORD_W + 1;

    localparam logic [COORD_W-1:0] L_GROUND = COORD_W'(GROUND_Y);
    localparam logic [COORD_W-1:0] L_INIT_X = COORD_W'(OBST_INIT_X);
    localparam logic [COORD_W-1:0] L_SPEED0 = COORD_W'(SPEED_INIT);
    localparam logic [CNT_W-1:0]   L_CNT0   = CNT_W'(SPAWN_GAP - 1);
    localparam logic [XW-1:0]      L_FOOT_X = XW'(DINO_X);
    localparam logic [XW-1:0]      L_HEAD_X = XW'(DINO_X + HEAD_DX);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
    state_t r_state, w_state_nxt;

    logic [COORD_W-1:0]                r_h, w_h_nxt;
    logic signed [COORD_W:0]           r_vel, w_vel_nxt;
    logic signed [COORD_W+1:0]         w_t;
    logic [NUM_OBST-1:0][COORD_W-1:0]  r_x, w_x_nxt;
    logic [NUM_OBST-1:0]               r_act, w_act_nxt, w_hit;
    logic [15:0]                       r_score, w_score_nxt;
    logic [16:0]                       w_sum, w_spd;
    logic [COORD_W-1:0]                r_speed, w_speed_nxt;
    logic [CNT_W-1:0]                  r_cnt, w_cnt_nxt;
    logic [RET_W-1:0]                  w_ret;
    logic                              w_spawned, w_start_run, w_step;
    logic [COORD_W-1:0]                r_dino_y;
    logic                              r_game_over;
    logic [XW-1:0]                     w_foot_y, w_head_y;

    // Collision uses one extra bit so x+OBST_W never wraps near the right screen edge.
    assign w_foot_y = {1'b0, r_h};
    assign w_head_y = w_foot_y + XW'(HEAD_DY);

    genvar g;
    generate
        for (g = 0; g < NUM_OBST; g++) begin : g_hit
            logic [XW-1:0] w_xl, w_xr;
            assign w_xl     = {1'b0, r_x[g]};
            assign w_xr     = w_xl + XW'(OBST_W);
            assign w_hit[g] = r_act[g] &&
                ((w_xl <= L_FOOT_X && L_FOOT_X < w_xr && w_foot_y < XW'(OBST_H)) ||
                 (w_xl <= L_HEAD_X && L_HEAD_X < w_xr && w_head_y < XW'(OBST_H)));
        end
    endgenerate

    assign w_start_run = (r_state != S_RUN) && start;
    assign w_step      = (r_state == S_RUN) && !(|w_hit);

    always_ff @(posedge game_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_OVER: if (start)  w_state_nxt = S_RUN;
            S_RUN:          if (|w_hit) w_state_nxt = S_OVER;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    assign w_t = $signed({2'b00, r_h}) + $signed({r_vel[COORD_W], r_vel});

    always_comb begin
        w_h_nxt   = r_h;
        w_vel_nxt = r_vel;
        if (r_h == '0 && r_vel == '0) begin
            if (jump) w_vel_nxt = XW'(JUMP_V);
        end else if (w_t <= 0) begin
            w_h_nxt   = '0;
            w_vel_nxt = '0;
        end else begin
            w_h_nxt   = w_t[COORD_W-1:0];
            w_vel_nxt = r_vel - XW'(GRAVITY);
        end
    end

    // Spawn looks at the pre-retire active mask, so a slot freed this frame waits a frame.
    always_comb begin
        w_x_nxt   = r_x;
        w_act_nxt = r_act;
        w_ret     = '0;
        w_spawned = 1'b0;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        for (int i = 0; i < NUM_OBST; i++) begin
            if (r_act[i]) begin
                if (r_x[i] < r_speed) begin
                    w_act_nxt[i] = 1'b0;
                    w_ret        = w_ret + RET_W'(1);
                end else begin
                    w_x_nxt[i] = r_x[i] - r_speed;
                end
            end
        end
        if (r_cnt == L_CNT0) begin
            w_cnt_nxt = r_cnt;
            for (int i = 0; i < NUM_OBST; i++) begin
                if (!r_act[i] && !w_spawned) begin
                    w_act_nxt[i] = 1'b1;
                    w_x_nxt[i]   = L_INIT_X;
                    w_spawned    = 1'b1;
                end
            end
            if (w_spawned) w_cnt_nxt = '0;
        end
    end

    assign w_sum       = {1'b0, r_score} + 17'(w_ret);
    assign w_score_nxt = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    assign w_spd       = 17'(SPEED_INIT) + 17'(w_score_nxt >> SHIFT);
    assign w_speed_nxt = (w_spd > 17'(SPEED_MAX)) ? COORD_W'(SPEED_MAX) : w_spd[COORD_W-1:0];

    always_ff @(posedge game_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h         <= '0;
            r_vel       <= '0;
            r_x         <= {NUM_OBST{L_INIT_X}};
            r_act       <= '0;
            r_score     <= '0;
            r_speed     <= L_SPEED0;
            r_cnt       <= L_CNT0;
            r_dino_y    <= L_GROUND;
            r_game_over <= 1'b0;
        end else if (w_start_run) begin
            r_h         <= '0;
            r_vel       <= '0;
            r_x         <= {NUM_OBST{L_INIT_X}};
            r_act       <= '0;
            r_score     <= '0;
            r_speed     <= L_SPEED0;
            r_cnt       <= L_CNT0;
            r_dino_y    <= L_GROUND;
            r_game_over <= 1'b0;
        end else if (w_step) begin
            r_h      <= w_h_nxt;
            r_vel    <= w_vel_nxt;
            r_x      <= w_x_nxt;
            r_act    <= w_act_nxt;
            r_score  <= w_score_nxt;
            r_speed  <= w_speed_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dino_y <= L_GROUND - w_h_nxt;
        end else if (r_state == S_RUN) begin
            // Collision frame: everything else freezes as-is.
            r_game_over <= 1'b1;
        end
    end

    assign dino_y      = r_dino_y;
    assign obstacle_x  = r_x;
    assign obst_active = r_act;
    assign score       = r_score;
    assign night       = r_score[NIGHT_BIT];
    assign game_over   = r_game_over;

endmodule
